// File: rtl/drop_host.sv
// drop_host: game-side initiator of the placement-request protocol.
// Pulls a tile from the feeder, asks the placement client where to put it,
// validates the answer and lands the piece on a per-column height map.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   i_start                pulse; leaves IDLE/OVER and clears the board
//   i_block_valid/_in      feeder handshake and tile code
//   o_block_ready          host accepts a tile this cycle
//   o_req_to_client        placement request, o_cur_block stable while high
//   i_resp_from_client     client answer valid, with i_opt_col/i_opt_rotation
//   o_busy                 not IDLE and not OVER
//   o_game_over            board overflowed
//   o_invalid_resp         sticky: out-of-range column seen
//   o_timeout_flag         sticky: client failed to answer in time
//   o_pieces_placed        saturating landed-piece count
//   i_dbg_col/o_dbg_height combinational height read-back port
module drop_host #(
  parameter int unsigned BOARD_W = 10,
  parameter int unsigned BOARD_H = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_block_valid,
  input  logic [3:0] i_block_in,
  output logic       o_block_ready,
  output logic       o_req_to_client,
  output logic [3:0] o_cur_block,
  input  logic       i_resp_from_client,
  input  logic [3:0] i_opt_col,
  input  logic [1:0] i_opt_rotation,
  output logic       o_busy,
  output logic       o_game_over,
  output logic       o_invalid_resp,
  output logic       o_timeout_flag,
  output logic [7:0] o_pieces_placed,
  input  logic [3:0] i_dbg_col,
  output logic [4:0] o_dbg_height
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [5:0] BoardW = 6'(BOARD_W);
  localparam logic [5:0] BoardH = 6'(BOARD_H);

  typedef enum logic [2:0] {StIdle, StFetch, StReq, StDrop, StPlace, StOver} state_e;

  state_e          r_state, w_state_d;
  logic [3:0]      r_cur_block, w_cur_block_d;
  logic [3:0]      r_col, w_col_d;
  logic [1:0]      r_rot, w_rot_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [7:0]      r_pieces, w_pieces_d;
  logic            r_game_over, w_game_over_d;
  logic            r_invalid, w_invalid_d;
  logic            r_timeout, w_timeout_d;
  logic [4:0]      r_heights [BOARD_W];
  logic [4:0]      w_heights_d [BOARD_W];

  // Piece geometry for the latched tile/answer.
  logic       w_square, w_vert, w_bad_col;
  logic [5:0] w_width_raw, w_end_raw;
  logic [5:0] w_col, w_width, w_height, w_end, w_base, w_top;
  logic       w_overflow;

  assign w_square    = (r_cur_block != 4'd0);
  assign w_vert      = !w_square && r_rot[0];
  assign w_width_raw = w_square ? 6'd2 : (w_vert ? 6'd1 : 6'd4);
  assign w_end_raw   = {2'b00, r_col} + w_width_raw;
  assign w_bad_col   = (w_end_raw > BoardW);
  // An out-of-range answer falls back to column 0 with rotation-0 geometry.
  assign w_col       = w_bad_col ? 6'd0 : {2'b00, r_col};
  assign w_width     = w_bad_col ? (w_square ? 6'd2 : 6'd4) : w_width_raw;
  assign w_height    = w_square ? 6'd2 : ((w_vert && !w_bad_col) ? 6'd4 : 6'd1);
  assign w_end       = w_col + w_width;

  always_comb begin
    w_base = 6'd0;
    for (int unsigned c = 0; c < BOARD_W; c++) begin
      if (6'(c) >= w_col && 6'(c) < w_end && {1'b0, r_heights[c]} > w_base) begin
        w_base = {1'b0, r_heights[c]};
      end
    end
  end

  assign w_top      = w_base + w_height;
  assign w_overflow = (w_top > BoardH);

  always_comb begin
    w_state_d     = r_state;
    w_cur_block_d = r_cur_block;
    w_col_d       = r_col;
    w_rot_d       = r_rot;
    w_cnt_d       = r_cnt;
    w_pieces_d    = r_pieces;
    w_game_over_d = r_game_over;
    w_invalid_d   = r_invalid;
    w_timeout_d   = r_timeout;
    for (int unsigned c = 0; c < BOARD_W; c++) begin
      w_heights_d[c] = r_heights[c];
    end

    case (r_state)
      StIdle, StOver: begin
        if (i_start) begin
          for (int unsigned c = 0; c < BOARD_W; c++) begin
            w_heights_d[c] = 5'd0;
          end
          w_pieces_d    = 8'd0;
          w_game_over_d = 1'b0;
          w_invalid_d   = 1'b0;
          w_timeout_d   = 1'b0;
          w_state_d     = StFetch;
        end
      end
      StFetch: begin
        if (i_block_valid) begin
          w_cur_block_d = i_block_in;
          w_cnt_d       = '0;
          w_state_d     = StReq;
        end
      end
      StReq: begin
        if (i_resp_from_client) begin
          w_col_d   = i_opt_col;
          w_rot_d   = i_opt_rotation;
          w_state_d = StDrop;
        end else if (r_cnt == CntLast) begin
          w_timeout_d = 1'b1;
          w_col_d     = 4'd0;
          w_rot_d     = 2'd0;
          w_state_d   = StDrop;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      // The client's registered response trails request removal by a cycle;
      // this state swallows it.
      StDrop: w_state_d = StPlace;
      StPlace: begin
        if (w_bad_col) begin
          w_invalid_d = 1'b1;
        end
        if (w_overflow) begin
          w_game_over_d = 1'b1;
          w_state_d     = StOver;
        end else begin
          for (int unsigned c = 0; c < BOARD_W; c++) begin
            if (6'(c) >= w_col && 6'(c) < w_end) begin
              w_heights_d[c] = w_top[4:0];
            end
          end
          if (r_pieces != 8'hFF) begin
            w_pieces_d = r_pieces + 8'd1;
          end
          w_state_d = StFetch;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cur_block <= 4'd0;
      r_col       <= 4'd0;
      r_rot       <= 2'd0;
      r_cnt       <= '0;
      r_pieces    <= 8'd0;
      r_game_over <= 1'b0;
      r_invalid   <= 1'b0;
      r_timeout   <= 1'b0;
      for (int unsigned c = 0; c < BOARD_W; c++) begin
        r_heights[c] <= 5'd0;
      end
    end else begin
      r_state     <= w_state_d;
      r_cur_block <= w_cur_block_d;
      r_col       <= w_col_d;
      r_rot       <= w_rot_d;
      r_cnt       <= w_cnt_d;
      r_pieces    <= w_pieces_d;
      r_game_over <= w_game_over_d;
      r_invalid   <= w_invalid_d;
      r_timeout   <= w_timeout_d;
      for (int unsigned c = 0; c < BOARD_W; c++) begin
        r_heights[c] <= w_heights_d[c];
      end
    end
  end

  always_comb begin
    o_dbg_height = 5'd0;
    for (int unsigned c = 0; c < BOARD_W; c++) begin
      if (i_dbg_col == 4'(c)) begin
        o_dbg_height = r_heights[c];
      end
    end
  end

  assign o_block_ready   = (r_state == StFetch);
  assign o_req_to_client = (r_state == StReq);
  assign o_busy          = (r_state != StIdle) && (r_state != StOver);
  assign o_cur_block     = r_cur_block;
  assign o_game_over     = r_game_over;
  assign o_invalid_resp  = r_invalid;
  assign o_timeout_flag  = r_timeout;
  assign o_pieces_placed = r_pieces;

endmodule

// File: tb/tb_drop_host.sv
// tb_drop_host: directed self-checking bench for drop_host.
module tb_drop_host;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start, i_block_valid, i_resp_from_client;
  logic [3:0] i_block_in, i_opt_col, i_dbg_col;
  logic [1:0] i_opt_rotation;
  logic       o_block_ready, o_req_to_client, o_busy, o_game_over;
  logic       o_invalid_resp, o_timeout_flag;
  logic [3:0] o_cur_block;
  logic [7:0] o_pieces_placed;
  logic [4:0] o_dbg_height;

  int n_checks = 0;
  int n_fails  = 0;

  drop_host #(.BOARD_W(10), .BOARD_H(16), .TIMEOUT(16)) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_start            (i_start),
    .i_block_valid      (i_block_valid),
    .i_block_in         (i_block_in),
    .o_block_ready      (o_block_ready),
    .o_req_to_client    (o_req_to_client),
    .o_cur_block        (o_cur_block),
    .i_resp_from_client (i_resp_from_client),
    .i_opt_col          (i_opt_col),
    .i_opt_rotation     (i_opt_rotation),
    .o_busy             (o_busy),
    .o_game_over        (o_game_over),
    .o_invalid_resp     (o_invalid_resp),
    .o_timeout_flag     (o_timeout_flag),
    .o_pieces_placed    (o_pieces_placed),
    .i_dbg_col          (i_dbg_col),
    .o_dbg_height       (o_dbg_height)
  );

  always #50 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_h(input int col, input int exp);
    i_dbg_col = 4'(col);
    #1;
    check_eq($sformatf("height[%0d]", col), int'(o_dbg_height), exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("busy_after_start", int'(o_busy), 1);
  endtask

  // Accept a tile, answer one cycle after the request, then run to the
  // cycle after PLACE.
  task automatic place_piece(input logic [3:0] tile, input logic [3:0] col,
                             input logic [1:0] rot);
    int n = 0;
    while (!o_block_ready && n < 20) begin
      tick();
      n++;
    end
    if (!o_block_ready) check_eq("ready_wait", int'(o_block_ready), 1);
    i_block_valid = 1'b1;
    i_block_in    = tile;
    tick();
    i_block_valid = 1'b0;
    check_eq("req_up", int'(o_req_to_client), 1);
    check_eq("cur_block", int'(o_cur_block), int'(tile));
    tick();
    i_resp_from_client = 1'b1;
    i_opt_col          = col;
    i_opt_rotation     = rot;
    tick();
    i_resp_from_client = 1'b0;
    check_eq("req_down_drop", int'(o_req_to_client), 0);
    tick();
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    i_start = 1'b0; i_block_valid = 1'b0; i_block_in = 4'd0;
    i_resp_from_client = 1'b0; i_opt_col = 4'd0; i_opt_rotation = 2'd0;
    i_dbg_col = 4'd0;
    #10;
    check_eq("rst_ready", int'(o_block_ready), 0);
    check_eq("rst_req", int'(o_req_to_client), 0);
    check_eq("rst_busy", int'(o_busy), 0);
    check_eq("rst_over", int'(o_game_over), 0);
    check_eq("rst_inv", int'(o_invalid_resp), 0);
    check_eq("rst_tmo", int'(o_timeout_flag), 0);
    check_eq("rst_pieces", int'(o_pieces_placed), 0);
    check_eq("rst_cur", int'(o_cur_block), 0);
    check_h(0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("idle_not_busy", int'(o_busy), 0);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("fetch_ready", int'(o_block_ready), 1);

    // Square at column 0; ready returns 4 cycles after accept.
    place_piece(4'd5, 4'd0, 2'd0);
    check_eq("ready_again", int'(o_block_ready), 1);
    check_h(0, 2); check_h(1, 2); check_h(2, 0);
    check_eq("pieces_1", int'(o_pieces_placed), 1);

    // Stacking: flat bar at 3, square at 4.
    place_piece(4'd0, 4'd3, 2'd0);
    check_h(3, 1); check_h(6, 1); check_h(7, 0);
    place_piece(4'd9, 4'd4, 2'd2);
    check_h(3, 1); check_h(4, 3); check_h(5, 3); check_h(6, 1);
    check_eq("pieces_3", int'(o_pieces_placed), 3);
    check_h(10, 0);

    // Vertical bar at the last column, then an out-of-range flat bar.
    restart();
    place_piece(4'd0, 4'd9, 2'd1);
    check_h(9, 4); check_h(8, 0);
    check_eq("inv_clear", int'(o_invalid_resp), 0);
    place_piece(4'd0, 4'd8, 2'd0);
    check_eq("inv_set", int'(o_invalid_resp), 1);
    check_h(0, 1); check_h(3, 1); check_h(4, 0); check_h(8, 0); check_h(9, 4);
    check_eq("pieces_inv", int'(o_pieces_placed), 2);

    // Timeout: request must stay up exactly 16 cycles.
    restart();
    i_block_valid = 1'b1;
    i_block_in    = 4'd7;
    i_opt_col     = 4'd6;
    tick();
    i_block_valid = 1'b0;
    n = 0;
    while (o_req_to_client && n < 40) begin
      n++;
      tick();
    end
    check_eq("req_cycles", n, 16);
    check_eq("tmo_set", int'(o_timeout_flag), 1);
    tick();
    tick();
    check_h(0, 2); check_h(1, 2); check_h(6, 0);
    check_eq("tmo_ready", int'(o_block_ready), 1);

    // Game over: eight squares fill column 0 exactly, the ninth overflows.
    restart();
    for (int k = 0; k < 8; k++) place_piece(4'd1, 4'd0, 2'd0);
    check_h(0, 16);
    check_eq("no_over_at_full", int'(o_game_over), 0);
    place_piece(4'd1, 4'd0, 2'd0);
    check_eq("over_set", int'(o_game_over), 1);
    check_eq("over_ready", int'(o_block_ready), 0);
    check_eq("over_busy", int'(o_busy), 0);
    check_eq("over_pieces", int'(o_pieces_placed), 8);
    check_h(0, 16); check_h(1, 16);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check_eq("restart_over", int'(o_game_over), 0);
    check_eq("restart_pieces", int'(o_pieces_placed), 0);
    check_h(0, 0);

    // Reset while the request is up.
    place_piece(4'd3, 4'd2, 2'd0);
    check_h(2, 2);
    i_block_valid = 1'b1;
    i_block_in    = 4'd4;
    tick();
    i_block_valid = 1'b0;
    check_eq("req_before_rst", int'(o_req_to_client), 1);
    i_resp_from_client = 1'b1;
    i_opt_col = 4'd5;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("req_async_drop", int'(o_req_to_client), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check_eq("rst_idle_busy", int'(o_busy), 0);
    check_eq("rst_idle_req", int'(o_req_to_client), 0);
    check_eq("rst_idle_cur", int'(o_cur_block), 0);
    check_h(2, 0); check_h(5, 0);
    i_resp_from_client = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/drop_host.md
Name: drop_host

Overview:
- Game-side initiator of the placement-request protocol.
- Pulls the next tile code from an upstream feeder and issues req_to_client with cur_block to the placement client.
- Waits for resp_from_client plus opt_col/opt_rotation, validates the answer, then lands the piece on a per-column height map.
- Tracks pieces placed and game-over; sits between the tile generator and the placement calculator.

Parameters:
- BOARD_W, 10: board columns, indices 0..BOARD_W-1 (max 15).
- BOARD_H, 16: board rows; column heights range 0..BOARD_H.
- TIMEOUT, 16: cycles in REQ without a response before fallback.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; leaves IDLE/OVER and clears the board
- block_valid  in  1  feeder has a tile
- block_in  in  4  tile code
- block_ready  out  1  host accepts a tile this cycle
- req_to_client  out  1  placement request
- cur_block  out  4  tile code, stable while req_to_client=1
- resp_from_client  in  1  client answer valid
- opt_col  in  4  leftmost anchor column from client
- opt_rotation  in  2  rotation from client
- busy  out  1  state is not IDLE and not OVER
- game_over  out  1  board overflowed
- invalid_resp  out  1  sticky: client gave an out-of-range column
- timeout_flag  out  1  sticky: client failed to answer
- pieces_placed  out  8  saturating count of landed pieces
- dbg_col  in  4  column select
- dbg_height  out  5  combinational height of dbg_col; 0 if dbg_col >= BOARD_W

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; all heights 0.
  - State IDLE.
  - cur_block 0, counters 0.
- Piece geometry:
  - Tile 0 = bar. Rotation 0/2 gives width 4, height 1; rotation 1/3 gives width 1, height 4.
  - Tiles 1..15 = 2x2 square, width 2, height 2; rotation ignored.
- States: IDLE, FETCH, REQ, DROP, PLACE, OVER.
- IDLE:
  - start=1 clears heights, pieces_placed, both sticky flags and game_over.
  - Then goes to FETCH.
- FETCH:
  - block_ready=1.
  - On block_valid=1: latch block_in into cur_block, go to REQ.
- REQ:
  - req_to_client=1; timeout counter increments each cycle.
  - resp_from_client=1: latch opt_col/opt_rotation, go to DROP.
  - Counter reaches TIMEOUT-1 with no response: set timeout_flag, use fallback col 0 / rot 0, go to DROP.
- DROP:
  - req_to_client=0.
  - resp_from_client is ignored for exactly this one cycle, because the client's registered response lags request removal by one cycle.
  - Then go to PLACE.
- PLACE (single cycle):
  - Validity check: if col + width > BOARD_W, set invalid_resp and substitute col 0 / rot 0 with the piece's rot-0 geometry.
  - base = max height over columns col..col+width-1.
  - If base + height > BOARD_H: set game_over, leave heights unchanged, go to OVER.
  - Otherwise set every footprint column to base + height, increment pieces_placed (saturate at 255), and go to FETCH.
  - base + height == BOARD_H is legal.
- OVER:
  - game_over held; block_ready=0.
  - start=1 behaves as in IDLE.
- start is ignored outside IDLE/OVER.
- Latency: tile accept edge -> req_to_client high next cycle.
  - With a client that answers one cycle after request, accept to heights update is 4 cycles.
  - block_ready is next high on the cycle after the PLACE update.
- Reset asserted mid-REQ: req_to_client drops asynchronously; heights clear.
- All arithmetic is unsigned, at least 5 bits wide, so col + width cannot wrap (max 15 + 4).

Test Plan:
- Square at col 0: start, feed tile 5, client answers col 0 rot 0 → heights[0]=heights[1]=2, pieces_placed=1, block_ready high again 4 cycles after accept.
- Stacking: bar col 3 rot 0 (heights 3..6 = 1), then square col 4 → heights[4]=heights[5]=3, heights[3]=heights[6]=1.
- Vertical bar and invalid column:
  - Bar rot 1 at col 9 → heights[9]=4.
  - Then bar rot 0 at col 8 → invalid_resp=1, landed at col 0 with heights[0..3]=1.
- Timeout: hold resp_from_client=0 → req_to_client high exactly 16 cycles, timeout_flag=1, piece at col 0 rot 0.
- Game over: eight squares at col 0 → heights[0]=16, no game_over; ninth → game_over=1, heights unchanged, pieces_placed=8; start clears everything.
- Reset mid-REQ: rst_n low for 1 cycle while req_to_client=1 → req_to_client=0 immediately, all heights 0, state IDLE; a lingering resp_from_client is ignored.
